// File: rtl/ps2_operation.sv
`timescale 1ns/1ps
// PS/2 keyboard front end: synchronize and filter the keyboard lines, assemble
// 11-bit frames, and turn make/break scan codes into one-cycle command pulses.
//
// state    | meaning
// ---------+-------------------------------------------
// NORMAL   | no prefix pending
// EXT      | E0 received, expecting extended code or F0
// BRK      | F0 received, next code is a break
// EXT_BRK  | E0 F0 received, next code is an extended break
module ps2_operation #(
   parameter int FILT    = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [4:0] operation,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [4:0] CMD_ENTER = 5'b10000;
   localparam logic [4:0] CMD_LEFT  = 5'b01000;
   localparam logic [4:0] CMD_UP    = 5'b00100;
   localparam logic [4:0] CMD_DOWN  = 5'b00010;
   localparam logic [4:0] CMD_RIGHT = 5'b00001;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } dec_state_t;

   logic            clk_s1_q, clk_s2_q;
   logic            dat_s1_q, dat_s2_q;
   logic [FILT-1:0] samp_q, samp_d;
   logic            filt_q, filt_d;
   logic            fall;
   logic [10:0]     frame_q, frame_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]      code_q, code_d;
   logic            code_vld_q, code_vld_d;
   logic            frame_err_q, frame_err_d;
   logic            frame_ok;
   logic [4:0]      held_q;
   logic [4:0]      op_q;
   logic [4:0]      cmd_norm, cmd_ext;
   dec_state_t      state_q;

   function automatic logic [4:0] map_norm(input logic [7:0] c);
      case (c)
         8'h1C:   map_norm = CMD_LEFT;
         8'h1D:   map_norm = CMD_UP;
         8'h1B:   map_norm = CMD_DOWN;
         8'h23:   map_norm = CMD_RIGHT;
         8'h5A:   map_norm = CMD_ENTER;
         default: map_norm = 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] map_ext(input logic [7:0] c);
      case (c)
         8'h6B:   map_ext = CMD_LEFT;
         8'h75:   map_ext = CMD_UP;
         8'h72:   map_ext = CMD_DOWN;
         8'h74:   map_ext = CMD_RIGHT;
         8'h5A:   map_ext = CMD_ENTER;
         default: map_ext = 5'b00000;
      endcase
   endfunction

   // Filtered clock moves only once the whole sample window agrees.
   always_comb begin
      samp_d = {samp_q[FILT-2:0], clk_s2_q};
      filt_d = filt_q;
      if (&samp_q)
         filt_d = 1'b1;
      else if (~|samp_q)
         filt_d = 1'b0;
   end

   assign fall     = filt_q & ~(|samp_q);
   assign frame_ok = ~frame_q[0] & (^frame_q[9:1]) & frame_q[10];

   always_comb begin
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      to_cnt_d    = to_cnt_q;
      code_d      = code_q;
      code_vld_d  = 1'b0;
      frame_err_d = 1'b0;
      if (bit_cnt_q == 4'd11) begin
         bit_cnt_d = 4'd0;
         if (frame_ok) begin
            code_d     = frame_q[8:1];
            code_vld_d = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end else if (fall) begin
         frame_d   = {dat_s2_q, frame_q[10:1]};
         bit_cnt_d = bit_cnt_q + 4'd1;
         to_cnt_d  = TW'(TIMEOUT - 1);
      end else if (bit_cnt_q != 4'd0) begin
         // Stalled partial frame: drop it quietly once the timer expires.
         if (to_cnt_q == '0) begin
            bit_cnt_d = 4'd0;
            frame_d   = '1;
         end else begin
            to_cnt_d = to_cnt_q - TW'(1);
         end
      end
   end

   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         samp_q      <= '1;
         filt_q      <= 1'b1;
         frame_q     <= '1;
         bit_cnt_q   <= 4'd0;
         to_cnt_q    <= '0;
         code_q      <= 8'h00;
         code_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_s1_q    <= ps2_clk;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= ps2_data;
         dat_s2_q    <= dat_s1_q;
         samp_q      <= samp_d;
         filt_q      <= filt_d;
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         to_cnt_q    <= to_cnt_d;
         code_q      <= code_d;
         code_vld_q  <= code_vld_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign cmd_norm = map_norm(code_q);
   assign cmd_ext  = map_ext(code_q);

   // Letter and arrow keys share held bits, so a second key for a command
   // already held is treated like a typematic repeat.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         state_q <= NORMAL;
         held_q  <= 5'b00000;
         op_q    <= 5'b00000;
      end else begin
         op_q <= 5'b00000;
         if (frame_err_q) begin
            state_q <= NORMAL;
         end else if (code_vld_q) begin
            case (state_q)
               NORMAL: begin
                  if (code_q == 8'hE0)
                     state_q <= EXT;
                  else if (code_q == 8'hF0)
                     state_q <= BRK;
                  else if ((held_q & cmd_norm) == 5'b00000) begin
                     held_q <= held_q | cmd_norm;
                     op_q   <= cmd_norm;
                  end
               end
               EXT: begin
                  if (code_q == 8'hF0)
                     state_q <= EXT_BRK;
                  else if (code_q == 8'hE0)
                     state_q <= EXT;
                  else begin
                     state_q <= NORMAL;
                     if ((held_q & cmd_ext) == 5'b00000) begin
                        held_q <= held_q | cmd_ext;
                        op_q   <= cmd_ext;
                     end
                  end
               end
               BRK: begin
                  held_q  <= held_q & ~cmd_norm;
                  state_q <= NORMAL;
               end
               EXT_BRK: begin
                  held_q  <= held_q & ~cmd_ext;
                  state_q <= NORMAL;
               end
               default: state_q <= NORMAL;
            endcase
         end
      end
   end

   assign operation = op_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_operation.sv
`timescale 1ns/1ps
// Bench for ps2_operation: bit-banged PS/2 frames from a vector table, with a
// scoreboard of expected command / frame-error pulses.
module tb_ps2_operation;

   localparam int FILT    = 4;
   localparam int TIMEOUT = 2000;
   localparam int HALF    = 30;

   localparam logic [4:0] NONE  = 5'b00000;
   localparam logic [4:0] ENTER = 5'b10000;
   localparam logic [4:0] LEFT  = 5'b01000;
   localparam logic [4:0] UP    = 5'b00100;
   localparam logic [4:0] DOWN  = 5'b00010;
   localparam logic [4:0] RIGHT = 5'b00001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [4:0] operation;
   logic       frame_err;

   always #5 clk = ~clk;

   ps2_operation #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
      .clk_100mhz (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .operation  (operation),
      .frame_err  (frame_err)
   );

   typedef struct {
      logic [7:0] code;
      logic       bad_par;
      logic       bad_stop;
      logic [4:0] op;
      logic       err;
   } vec_t;

   typedef struct {
      logic [4:0] op;
      logic       err;
   } ev_t;

   vec_t vq[$];
   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Every output pulse must match the oldest expected event; a stretched
   // pulse shows up as an unexpected second event.
   always @(negedge clk) begin : monitor
      ev_t e;
      if (!rst && (operation != 5'b00000 || frame_err)) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: operation=%b frame_err=%b, expected no event",
                     operation, frame_err);
         end else begin
            e = exp_q.pop_front();
            if (operation !== e.op || frame_err !== e.err) begin
               n_bad++;
               $display("FAIL event: operation=%b frame_err=%b, expected operation=%b frame_err=%b",
                        operation, frame_err, e.op, e.err);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad_par,
                             input logic bad_stop, input int nbits);
      logic [10:0] f;
      f = {1'b1 ^ bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         idle(HALF);
         ps2_clk = 1'b0;
         if (i == 10) begin
            lat = -1;
            for (int k = 1; k <= HALF; k++) begin
               @(posedge clk);
               @(negedge clk);
               if (lat < 0 && operation != 5'b00000) lat = k;
            end
         end else begin
            idle(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      idle(HALF);
   endtask

   task automatic expect_ev(input logic [4:0] op, input logic err);
      ev_t e;
      e.op  = op;
      e.err = err;
      if (op != 5'b00000 || err) exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      idle(10);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic add(input logic [7:0] code, input logic bp, input logic bs,
                      input logic [4:0] op, input logic err);
      vec_t v;
      v.code = code; v.bad_par = bp; v.bad_stop = bs; v.op = op; v.err = err;
      vq.push_back(v);
   endtask

   initial begin
      // Repeat / break of up, first 1D sent by hand below.
      add(8'h1D,0,0,NONE,0);  add(8'h1D,0,0,NONE,0);
      add(8'hF0,0,0,NONE,0);  add(8'h1D,0,0,NONE,0);
      add(8'h1D,0,0,UP,0);
      add(8'hF0,0,0,NONE,0);  add(8'h1D,0,0,NONE,0);
      // Extended right: make, break, make again, release.
      add(8'hE0,0,0,NONE,0);  add(8'h74,0,0,RIGHT,0);
      add(8'hE0,0,0,NONE,0);  add(8'hF0,0,0,NONE,0);  add(8'h74,0,0,NONE,0);
      add(8'hE0,0,0,NONE,0);  add(8'h74,0,0,RIGHT,0);
      add(8'hE0,0,0,NONE,0);  add(8'hF0,0,0,NONE,0);  add(8'h74,0,0,NONE,0);
      // Shared held bit between letter and arrow.
      add(8'h23,0,0,RIGHT,0);
      add(8'hE0,0,0,NONE,0);  add(8'h74,0,0,NONE,0);
      add(8'hF0,0,0,NONE,0);  add(8'h23,0,0,NONE,0);
      add(8'hE0,0,0,NONE,0);  add(8'h74,0,0,RIGHT,0);
      add(8'hE0,0,0,NONE,0);  add(8'hF0,0,0,NONE,0);  add(8'h74,0,0,NONE,0);
      // Bad parity, then good enter.
      add(8'h5A,1,0,NONE,1);  add(8'h5A,0,0,ENTER,0);
      add(8'hF0,0,0,NONE,0);  add(8'h5A,0,0,NONE,0);
      // Left: extended break releases the letter's bit.
      add(8'h1C,0,0,LEFT,0);
      add(8'hE0,0,0,NONE,0);  add(8'h6B,0,0,NONE,0);
      add(8'hE0,0,0,NONE,0);  add(8'hF0,0,0,NONE,0);  add(8'h6B,0,0,NONE,0);
      add(8'h1C,0,0,LEFT,0);
      add(8'hF0,0,0,NONE,0);  add(8'h1C,0,0,NONE,0);
      // Bad stop after E0 drops the prefix: 74 alone is unmapped.
      add(8'hE0,0,0,NONE,0);  add(8'h74,0,1,NONE,1);  add(8'h74,0,0,NONE,0);
      add(8'h1B,0,0,DOWN,0);
      add(8'hE0,0,0,NONE,0);  add(8'h75,0,0,UP,0);
      add(8'hE0,0,0,NONE,0);  add(8'h72,0,0,NONE,0);
      add(8'h15,0,0,NONE,0);
      add(8'hF0,0,0,NONE,0);  add(8'h1B,0,0,NONE,0);
      add(8'hE0,0,0,NONE,0);  add(8'h72,0,0,DOWN,0);

      // Reset state.
      idle(5);
      chk("reset_operation", operation, 0);
      chk("reset_frame_err", frame_err, 0);
      rst = 1'b0;
      idle(20);

      // Single 0x1D frame with latency from the stop-bit clock edge.
      expect_ev(UP, 1'b0);
      send_frame(8'h1D, 1'b0, 1'b0, 11);
      chk("up_latency", lat, FILT + 5);
      check_drained("first_1d_pending");

      foreach (vq[i]) begin
         expect_ev(vq[i].op, vq[i].err);
         send_frame(vq[i].code, vq[i].bad_par, vq[i].bad_stop, 11);
         check_drained($sformatf("vec%0d_code%02h_pending", i, vq[i].code));
      end

      // Partial frame abandoned by the timeout, then a clean 1C.
      send_frame(8'h1C, 1'b0, 1'b0, 5);
      idle(TIMEOUT + 400);
      check_drained("partial_no_event");
      expect_ev(LEFT, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check_drained("after_timeout_1c");
      send_frame(8'hF0, 1'b0, 1'b0, 11);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check_drained("release_left");

      // Short clock glitch while idle must not count as a bit.
      ps2_clk = 1'b0;
      idle(FILT - 1);
      ps2_clk = 1'b1;
      idle(50);
      expect_ev(RIGHT, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0, 11);
      check_drained("after_glitch_23");

      // Reset mid-frame: partial discarded, held mask cleared.
      send_frame(8'h74, 1'b0, 1'b0, 5);
      rst = 1'b1;
      idle(3);
      chk("midreset_operation", operation, 0);
      chk("midreset_frame_err", frame_err, 0);
      rst = 1'b0;
      idle(20);
      expect_ev(RIGHT, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0, 11);
      check_drained("after_reset_23");

      chk("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
